hgc_pixel_serializer: RTL
=========================

// Module: hgc_pixel_serializer
// PURPOSE
// - Parametrised text/graphics pixel serializer for the MDA/Hercules display path; successor to the fixed 9-dot HGC pixel block.
// - Fetches glyph rows from an external char ROM; serializes 8/9-dot text cells or 16-dot graphics words.
// - Delays attribute/cursor/enable so they align with the cell being shifted; feeds the attribute stage.
// PARAMETERS
// - CHAR_W    9  dots per text cell; legal values 8 or 9.
// - ROW_BITS  4  glyph row address width; ROM depth = 2^(8+ROW_BITS).
// PORTS
// - clk            in   1           pixel-domain clock
// - reset_n        in   1           asynchronous reset, active low
// - load           in   1           char-boundary strobe, 1 clk pulse per cell
// - dot_en         in   1           dot clock enable, 1 dot per asserted clk
// - video_enabled  in   1           0 blanks the cell captured at load
// - grph_mode      in   1           1 = 16-dot graphics cells, 0 = text
// - char_code      in   8           text char byte; sampled on load
// - attr_in        in   8           text attribute byte; sampled on load
// - gfx_data       in   16          graphics word; sampled on load
// - row_addr       in   ROW_BITS    glyph row of the current scanline
// - cursor         in   1           cursor active; sampled on load
// - display_enable in   1           CRTC display enable; sampled on load
// - rom_addr       out  8+ROW_BITS  {char_code, row_addr}, registered
// - rom_data       in   8           ROM data, valid 1 clk after rom_addr
// - pix            out  1           serialized pixel, registered
// - attr_out       out  8           attribute of the cell now shifting
// - cursor_out     out  1           cursor flag of the cell now shifting
// - de_out         out  1           display enable of the cell now shifting
// - fetch_ovr      out  1           1-clk pulse: load arrived before the glyph fetch completed
// BEHAVIOUR
// - Reset: every register and output = 0; fetch FSM = IDLE.
// - Two-stage pipe. On load, the fetch stage captures char_code, attr_in, gfx_data, cursor and display_enable.
//   In the same cycle the display stage takes over the previously staged cell.
//   Latency: pixels of the cell captured at load N appear from load N+1 onward.
// - Fetch FSM: IDLE -load-> ADDR (rom_addr updated) -> CAPT (rom_data -> glyph_stage) -> IDLE.
//   A load in ADDR or CAPT restarts at ADDR and pulses fetch_ovr for 1 clk.
//   The display stage then takes the stale glyph_stage unchanged.
//   Loads must therefore be >= 3 clk apart.
// - Text shifter: on load, shift_reg <= {glyph_stage, ninth}; the ninth bit is used only when CHAR_W=9.
//   Dot counter <= 0 on load.
//   On each dot_en: pix <= shift_reg MSB, shift left, counter +1.
//   Once counter reaches CHAR_W: pix = 0 until the next load (no wrap).
// - Graphics: on load, shift_reg <= gfx_data staged at the previous load.
//   16 dots, MSB first (even byte first).
//   CHAR_W ignored; attr_out = 0 and cursor_out = 0 in grph_mode.
// - Blanking: video_enabled=0 at load -> that cell stages all-zero glyph/gfx and attr 0.
//   de_out and cursor_out are still delayed normally.
// - attr_out, cursor_out, de_out update in the same clk the shifter loads; constant for the whole cell.
// - load and dot_en in the same clk: load wins; the dot is not consumed.
// - grph_mode is sampled at load and applies per cell; mid-cell changes are ignored.
// - reset_n low mid-cell: pix and all outputs go to 0 immediately (async); the first cell after release is blank.
// CONFIGURATION
// - LINE_GRAPHICS_EN defined: when CHAR_W=9 and staged char_code[7:5]==3'b110, ninth = glyph bit0 (box-drawing continuity).
//   Otherwise ninth = 0.
// - LINE_GRAPHICS_EN undefined: ninth column is always 0.
// TESTING
// - Reset: reset_n low mid-cell with pix=1 -> pix, attr_out, de_out, rom_addr = 0 within the same clk.
// - CHAR_W=9, text: load 0x41, ROM returns 0x3C, then load again.
//   9 dot_en -> pix 0,0,1,1,1,1,0,0,0; attr_out = attr of first load.
// - LINE_GRAPHICS_EN, CHAR_W=9: char 0xC4, ROM 0x81 -> dot 9 = 1. Char 0x44, ROM 0x81 -> dot 9 = 0.
//   Macro off, char 0xC4 -> dot 9 = 0.
// - grph_mode: gfx_data 0xA55A, next load, 16 dot_en -> pix 1010010101011010; attr_out = 0, cursor_out = 0.
// - Loads 2 clk apart -> fetch_ovr high for 1 clk; the shifted glyph equals the previously staged one.
// - CHAR_W=8: 10 dot_en after load -> dots 9 and 10 = 0. load+dot_en in the same clk -> first dot = glyph bit7.

Source files
------------

// File: rtl/hgc_pixel_serializer_if.sv
// Pixel-serializer bus: cell inputs, char-ROM fetch port and the aligned pixel/attribute outputs.
// The serializer is the slave; the ROM/CRTC side is the master.
interface hgc_pixel_serializer_if #(
  parameter int ROW_BITS = 4
) ();
  logic                  load;
  logic                  dot_en;
  logic                  video_enabled;
  logic                  grph_mode;
  logic [7:0]            char_code;
  logic [7:0]            attr_in;
  logic [15:0]           gfx_data;
  logic [ROW_BITS-1:0]   row_addr;
  logic                  cursor;
  logic                  display_enable;
  logic [7+ROW_BITS:0]   rom_addr;
  logic [7:0]            rom_data;
  logic                  pix;
  logic [7:0]            attr_out;
  logic                  cursor_out;
  logic                  de_out;
  logic                  fetch_ovr;

  modport master (
    output load, dot_en, video_enabled, grph_mode, char_code, attr_in, gfx_data,
           row_addr, cursor, display_enable, rom_data,
    input  rom_addr, pix, attr_out, cursor_out, de_out, fetch_ovr
  );

  modport slave (
    input  load, dot_en, video_enabled, grph_mode, char_code, attr_in, gfx_data,
           row_addr, cursor, display_enable, rom_data,
    output rom_addr, pix, attr_out, cursor_out, de_out, fetch_ovr
  );
endinterface

// File: rtl/hgc_pixel_serializer.sv
// MDA/Hercules pixel serializer: two-stage fetch/display pipe for 8/9-dot text or 16-dot graphics cells.
// Optional LINE_GRAPHICS_EN: 9th text column copies glyph bit0 for chars 0xC0-0xDF (box drawing).
module hgc_pixel_serializer #(
  parameter int CHAR_W   = 9,
  parameter int ROW_BITS = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  hgc_pixel_serializer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR, CAPT} fetch_state_e;

  fetch_state_e        state_q, state_d;
  logic [7+ROW_BITS:0] rom_addr_q;
  logic                fetch_ovr_q;

  // Fetch stage: the cell captured at the most recent load
  logic [7:0]  attr_stage_q;
  logic [7:0]  glyph_stage_q;
  logic [15:0] gfx_stage_q;
  logic        cursor_stage_q, de_stage_q, grph_stage_q, blank_stage_q;

  // Display stage: the cell currently being shifted out
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        pix_q, pix_d;
  logic        cell_grph_q;
  logic [7:0]  attr_out_q;
  logic        cursor_out_q, de_out_q;
  logic        ninth;
  logic [4:0]  dot_limit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      ADDR:    state_d = CAPT;
      CAPT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.load) state_d = ADDR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rom_addr_q     <= '0;
      fetch_ovr_q    <= 1'b0;
      attr_stage_q   <= '0;
      glyph_stage_q  <= '0;
      gfx_stage_q    <= '0;
      cursor_stage_q <= 1'b0;
      de_stage_q     <= 1'b0;
      grph_stage_q   <= 1'b0;
      blank_stage_q  <= 1'b0;
      attr_out_q     <= '0;
      cursor_out_q   <= 1'b0;
      de_out_q       <= 1'b0;
      cell_grph_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_ovr_q <= bus.load && (state_q != IDLE);
      // NOTE: non-blocking, so the display stage below reads the old staged cell in the same
      // clock that the fetch stage overwrites it.
      if (bus.load) begin
        rom_addr_q     <= {bus.char_code, bus.row_addr};
        attr_stage_q   <= bus.video_enabled ? bus.attr_in : 8'h00;
        gfx_stage_q    <= bus.video_enabled ? bus.gfx_data : 16'h0000;
        cursor_stage_q <= bus.cursor;
        de_stage_q     <= bus.display_enable;
        grph_stage_q   <= bus.grph_mode;
        blank_stage_q  <= !bus.video_enabled;
        attr_out_q     <= grph_stage_q ? 8'h00 : attr_stage_q;
        cursor_out_q   <= grph_stage_q ? 1'b0 : cursor_stage_q;
        de_out_q       <= de_stage_q;
        cell_grph_q    <= grph_stage_q;
      end else if (state_q == CAPT) begin
        glyph_stage_q <= blank_stage_q ? 8'h00 : bus.rom_data;
      end
    end
  end

`ifdef LINE_GRAPHICS_EN
  logic [7:0] char_stage_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      char_stage_q <= '0;
    else if (bus.load) char_stage_q <= bus.char_code;
  end

  assign ninth = (CHAR_W == 9) && (char_stage_q[7:5] == 3'b110) && glyph_stage_q[0];
`else
  assign ninth = 1'b0;
`endif

  assign dot_limit = cell_grph_q ? 5'd16 : 5'(CHAR_W);

  // A load takes priority over a coincident dot_en; the counter stops at the cell width (no wrap).
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    if (bus.load) begin
      shift_d = grph_stage_q ? gfx_stage_q : {glyph_stage_q, ninth, 7'b0};
      cnt_d   = '0;
    end else if (bus.dot_en) begin
      if (cnt_q < dot_limit) begin
        pix_d   = shift_q[15];
        shift_d = {shift_q[14:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
      end else begin
        pix_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      pix_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.pix        = pix_q;
  assign bus.attr_out   = attr_out_q;
  assign bus.cursor_out = cursor_out_q;
  assign bus.de_out     = de_out_q;
  assign bus.fetch_ovr  = fetch_ovr_q;

endmodule
